// File: rtl/i2c_eeprom_seq.sv
// Multi-byte EEPROM burst sequencer in front of i2c_dri: splits a burst into single-byte
// exec/done operations, with write-cycle delay, NACK retry and optional read-back verify.
module i2c_eeprom_seq #(
    parameter int ADDR_W    = 16,
    parameter int LEN_W     = 6,
    parameter int WR_CYCLE  = 10000,
    parameter int RETRY_MAX = 3
) (
    input  logic              dri_clk,
    input  logic              sys_rst_n,
    input  logic              start,
    input  logic [1:0]        mode,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [LEN_W-1:0]  len,
    output logic              wr_req,
    input  logic [7:0]        wr_data,
    output logic [7:0]        rd_data,
    output logic              rd_valid,
    output logic [LEN_W-1:0]  byte_idx,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [1:0]        err_code,
    output logic              i2c_exec,
    output logic              bit_ctrl,
    output logic              i2c_rh_wl,
    output logic [15:0]       i2c_addr,
    output logic [7:0]        i2c_data_w,
    input  logic [7:0]        i2c_data_r,
    input  logic              i2c_done,
    input  logic              i2c_ack
);
    localparam int CNT_W = $clog2(WR_CYCLE + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_ISSUE, S_WAIT, S_WR_DLY, S_NEXT, S_DONE
    } state_t;

    state_t            state, state_nxt;
    logic [1:0]        mode_r;
    logic [ADDR_W-1:0] base_r;
    logic [ADDR_W-1:0] addr_sum;
    logic [LEN_W-1:0]  len_r;
    logic [3:0]        retry;
    logic [CNT_W-1:0]  dly_cnt;
    logic              verify_ph;
    logic              dly_retry;
    logic              bad_req, last_byte, dly_end, is_read_op, can_retry;

    assign bad_req    = (len == '0) || (mode == 2'b11);
    assign is_read_op = (mode_r == 2'b01) || verify_ph;
    assign last_byte  = (byte_idx == len_r - 1'b1);
    assign dly_end    = (dly_cnt == CNT_W'(WR_CYCLE - 1));
    assign can_retry  = (retry < 4'(RETRY_MAX));

    assign addr_sum   = base_r + ADDR_W'(byte_idx);
    assign i2c_addr   = 16'(addr_sum);
    assign i2c_rh_wl  = is_read_op;
    assign bit_ctrl   = (ADDR_W == 16);

    always_ff @(posedge dri_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) state <= S_IDLE;
        else            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        wr_req    = 1'b0;
        i2c_exec  = 1'b0;
        done      = 1'b0;
        busy      = (state != S_IDLE) && (state != S_DONE);
        case (state)
            S_IDLE: begin
                if (start) begin
                    if (bad_req)             state_nxt = S_DONE;
                    else if (mode == 2'b01)  state_nxt = S_ISSUE;
                    else                     state_nxt = S_LOAD;
                end
            end
            S_LOAD: begin
                wr_req    = 1'b1;
                state_nxt = S_ISSUE;
            end
            S_ISSUE: begin
                i2c_exec  = 1'b1;
                state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (i2c_done) begin
                    if (i2c_ack)         state_nxt = can_retry ? S_WR_DLY : S_DONE;
                    else if (is_read_op) state_nxt = S_NEXT;
                    else                 state_nxt = S_WR_DLY;
                end
            end
            S_WR_DLY: begin
                // a retry re-issues the same op; an acked write in mode 10 moves on to its read-back
                if (dly_end) state_nxt = (dly_retry || mode_r == 2'b10) ? S_ISSUE : S_NEXT;
            end
            S_NEXT: begin
                if (last_byte)            state_nxt = S_DONE;
                else if (mode_r == 2'b01) state_nxt = S_ISSUE;
                else                      state_nxt = S_LOAD;
            end
            S_DONE: begin
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge dri_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            mode_r     <= '0;
            base_r     <= '0;
            len_r      <= '0;
            byte_idx   <= '0;
            retry      <= '0;
            dly_cnt    <= '0;
            verify_ph  <= 1'b0;
            dly_retry  <= 1'b0;
            i2c_data_w <= '0;
            rd_data    <= '0;
            rd_valid   <= 1'b0;
            err        <= 1'b0;
            err_code   <= 2'b00;
        end else begin
            rd_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        mode_r    <= mode;
                        base_r    <= base_addr;
                        len_r     <= len;
                        byte_idx  <= '0;
                        retry     <= '0;
                        verify_ph <= 1'b0;
                        dly_retry <= 1'b0;
                        err       <= bad_req;
                        err_code  <= bad_req ? 2'b11 : 2'b00;
                    end
                end
                S_LOAD: i2c_data_w <= wr_data;
                S_WAIT: begin
                    if (i2c_done) begin
                        if (i2c_ack) begin
                            dly_retry <= 1'b1;
                            if (can_retry) begin
                                retry <= retry + 1'b1;
                            end else begin
                                if (!err) err_code <= 2'b01;
                                err <= 1'b1;
                            end
                        end else if (is_read_op) begin
                            rd_data  <= i2c_data_r;
                            rd_valid <= !verify_ph;
                            if (verify_ph && (i2c_data_r != i2c_data_w)) begin
                                if (!err) err_code <= 2'b10;
                                err <= 1'b1;
                            end
                        end else begin
                            dly_retry <= 1'b0;
                        end
                    end
                end
                S_WR_DLY: begin
                    if (dly_end) begin
                        dly_cnt <= '0;
                        if (!dly_retry && mode_r == 2'b10) verify_ph <= 1'b1;
                    end else begin
                        dly_cnt <= dly_cnt + 1'b1;
                    end
                end
                S_NEXT: begin
                    retry     <= '0;
                    verify_ph <= 1'b0;
                    if (!last_byte) byte_idx <= byte_idx + 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_i2c_eeprom_seq.sv
// Bench for i2c_eeprom_seq: a behavioural i2c_dri/EEPROM slave plus directed and randomized
// bursts, with expectations built from plain burst arithmetic.
module tb_i2c_eeprom_seq;
    localparam int ADDR_W = 16, LEN_W = 6, WR_CYCLE = 40, RETRY_MAX = 3;

    logic        dri_clk = 1'b0, sys_rst_n = 1'b0, start = 1'b0;
    logic [1:0]  mode = 2'b00;
    logic [15:0] base_addr = '0;
    logic [5:0]  len = '0;
    logic        wr_req, rd_valid, busy, done, err, i2c_exec, bit_ctrl, i2c_rh_wl;
    logic [7:0]  wr_data, rd_data, i2c_data_w;
    logic [5:0]  byte_idx;
    logic [1:0]  err_code;
    logic [15:0] i2c_addr;
    logic [7:0]  i2c_data_r = '0;
    logic        i2c_done = 1'b0, i2c_ack = 1'b0;

    always #5 dri_clk = ~dri_clk;

    i2c_eeprom_seq #(.ADDR_W(ADDR_W), .LEN_W(LEN_W), .WR_CYCLE(WR_CYCLE), .RETRY_MAX(RETRY_MAX)) dut (
        .dri_clk(dri_clk), .sys_rst_n(sys_rst_n), .start(start), .mode(mode),
        .base_addr(base_addr), .len(len), .wr_req(wr_req), .wr_data(wr_data),
        .rd_data(rd_data), .rd_valid(rd_valid), .byte_idx(byte_idx), .busy(busy),
        .done(done), .err(err), .err_code(err_code), .i2c_exec(i2c_exec),
        .bit_ctrl(bit_ctrl), .i2c_rh_wl(i2c_rh_wl), .i2c_addr(i2c_addr),
        .i2c_data_w(i2c_data_w), .i2c_data_r(i2c_data_r), .i2c_done(i2c_done), .i2c_ack(i2c_ack)
    );

    // user-side write buffer, presented by byte index
    logic [7:0] wbuf [64];
    assign wr_data = wbuf[byte_idx];

    // slave model: logs each exec, answers after a random latency, NACKs on demand
    logic [7:0]  mem [65536];
    logic [15:0] ex_addr_q [$];
    logic        ex_rw_q [$];
    logic [7:0]  ex_dat_q [$];
    logic        pend = 1'b0, op_rw = 1'b0, op_nack = 1'b0;
    logic [15:0] op_addr = '0;
    logic [7:0]  op_dat = '0;
    int          lat = 0;
    int          nack_until = 0;
    logic        nack_all = 1'b0;
    int          corrupt_addr = -1;

    always @(posedge dri_clk) begin
        i2c_done <= 1'b0;
        if (!sys_rst_n) begin
            pend <= 1'b0;
        end else if (i2c_exec) begin
            op_nack <= (ex_addr_q.size() < nack_until) || nack_all;
            ex_addr_q.push_back(i2c_addr);
            ex_rw_q.push_back(i2c_rh_wl);
            ex_dat_q.push_back(i2c_data_w);
            op_addr <= i2c_addr;
            op_rw   <= i2c_rh_wl;
            op_dat  <= i2c_data_w;
            lat     <= $urandom_range(1, 5);
            pend    <= 1'b1;
        end else if (pend) begin
            if (lat == 0) begin
                pend     <= 1'b0;
                i2c_done <= 1'b1;
                i2c_ack  <= op_nack;
                if (!op_nack) begin
                    if (op_rw) i2c_data_r <= (int'(op_addr) == corrupt_addr) ? ~mem[op_addr] : mem[op_addr];
                    else       mem[op_addr] <= op_dat;
                end
            end else begin
                lat <= lat - 1;
            end
        end
    end

    logic [7:0] rd_q [$];
    int         done_cnt = 0;
    always @(posedge dri_clk) begin
        if (rd_valid) rd_q.push_back(rd_data);
        if (done) done_cnt <= done_cnt + 1;
    end

    int tests = 0, fails = 0;
    int ex0, rd0, dn0, cycles;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic launch(input logic [1:0] m, input logic [15:0] b, input logic [5:0] l);
        ex0 = ex_addr_q.size();
        rd0 = rd_q.size();
        dn0 = done_cnt;
        @(negedge dri_clk);
        mode = m; base_addr = b; len = l; start = 1'b1;
        @(negedge dri_clk);
        start = 1'b0;
    endtask

    task automatic burst(input string tag, input logic [1:0] m, input logic [15:0] b, input logic [5:0] l);
        launch(m, b, l);
        cycles = 1;
        while (!done && cycles < 20000) begin
            @(negedge dri_clk);
            cycles++;
        end
        chk({tag, "_done"}, done, 1'b1);
        @(negedge dri_clk);
        chk({tag, "_done_once"}, done_cnt - dn0, 1);
        chk({tag, "_busy_off"}, busy, 1'b0);
    endtask

    // op k of the current burst must target address a with direction rw
    task automatic chk_exec(input string tag, input int k, input logic [15:0] a, input logic rw);
        chk({tag, "_addr"}, ex_addr_q[ex0 + k], a);
        chk({tag, "_rw"}, ex_rw_q[ex0 + k], rw);
    endtask

    task automatic chk_quiet_outputs(input string tag);
        chk({tag, "_busy"}, busy, 1'b0);
        chk({tag, "_done"}, done, 1'b0);
        chk({tag, "_exec"}, i2c_exec, 1'b0);
        chk({tag, "_wr_req"}, wr_req, 1'b0);
        chk({tag, "_rd_valid"}, rd_valid, 1'b0);
        chk({tag, "_err"}, err, 1'b0);
        chk({tag, "_err_code"}, err_code, 2'b00);
        chk({tag, "_addr"}, i2c_addr, 16'h0000);
        chk({tag, "_rh_wl"}, i2c_rh_wl, 1'b0);
        chk({tag, "_data_w"}, i2c_data_w, 8'h00);
        chk({tag, "_rd_data"}, rd_data, 8'h00);
        chk({tag, "_byte_idx"}, byte_idx, 6'd0);
        chk({tag, "_bit_ctrl"}, bit_ctrl, 1'b1);
    endtask

    initial begin
        logic [15:0] b, b1;
        logic [5:0]  l;
        for (int i = 0; i < 64; i++) wbuf[i] = 8'h00;

        repeat (3) @(negedge dri_clk);
        chk_quiet_outputs("reset");
        sys_rst_n = 1'b1;
        @(negedge dri_clk);

        // single write byte
        wbuf[0] = 8'hAA;
        burst("t1", 2'b00, 16'h0555, 6'd1);
        chk("t1_nexec", ex_addr_q.size() - ex0, 1);
        chk_exec("t1", 0, 16'h0555, 1'b0);
        chk("t1_data", ex_dat_q[ex0], 8'hAA);
        chk("t1_wr_delay", cycles >= WR_CYCLE, 1'b1);
        chk("t1_err", err, 1'b0);

        // fixed 4-byte pattern written then read back
        wbuf[0] = 8'h11; wbuf[1] = 8'h22; wbuf[2] = 8'h33; wbuf[3] = 8'h44;
        burst("t2w", 2'b00, 16'h0555, 6'd4);
        burst("t2r", 2'b01, 16'h0555, 6'd4);
        chk("t2_nexec", ex_addr_q.size() - ex0, 4);
        chk("t2_nrd", rd_q.size() - rd0, 4);
        for (int i = 0; i < 4; i++) begin
            chk_exec("t2", i, 16'h0555 + 16'(i), 1'b1);
            chk("t2_rd", rd_q[rd0 + i], wbuf[i]);
        end
        chk("t2_err", err, 1'b0);

        // random write/read-back bursts
        repeat (3) begin
            b = 16'($urandom);
            l = 6'($urandom_range(1, 6));
            for (int i = 0; i < 64; i++) wbuf[i] = 8'($urandom);
            burst("rw_w", 2'b00, b, l);
            chk("rw_w_nexec", ex_addr_q.size() - ex0, int'(l));
            for (int i = 0; i < int'(l); i++) begin
                chk_exec("rw_w", i, b + 16'(i), 1'b0);
                chk("rw_w_data", ex_dat_q[ex0 + i], wbuf[i]);
            end
            burst("rw_r", 2'b01, b, l);
            chk("rw_r_nrd", rd_q.size() - rd0, int'(l));
            for (int i = 0; i < int'(l); i++) chk("rw_r_data", rd_q[rd0 + i], wbuf[i]);
        end

        // write+verify with byte 1 corrupted on read-back
        b = 16'($urandom);
        b1 = b + 16'd1;
        wbuf[0] = 8'($urandom); wbuf[1] = 8'($urandom);
        corrupt_addr = int'(b1);
        burst("t3", 2'b10, b, 6'd2);
        corrupt_addr = -1;
        chk("t3_nexec", ex_addr_q.size() - ex0, 4);
        chk_exec("t3_0", 0, b, 1'b0);
        chk_exec("t3_1", 1, b, 1'b1);
        chk_exec("t3_2", 2, b1, 1'b0);
        chk_exec("t3_3", 3, b1, 1'b1);
        chk("t3_nrd", rd_q.size() - rd0, 0);
        chk("t3_err", err, 1'b1);
        chk("t3_err_code", err_code, 2'b10);

        // clean verify burst
        b = 16'($urandom);
        l = 6'($urandom_range(1, 4));
        for (int i = 0; i < 64; i++) wbuf[i] = 8'($urandom);
        burst("t3c", 2'b10, b, l);
        chk("t3c_nexec", ex_addr_q.size() - ex0, 2 * int'(l));
        chk("t3c_err", err, 1'b0);

        // two NACKs then success on the same address
        b = 16'($urandom);
        nack_until = ex_addr_q.size() + 2;
        burst("t4", 2'b00, b, 6'd1);
        chk("t4_nexec", ex_addr_q.size() - ex0, 3);
        for (int i = 0; i < 3; i++) chk_exec("t4", i, b, 1'b0);
        chk("t4_err", err, 1'b0);

        // permanent NACK exhausts retries and abandons the burst
        nack_all = 1'b1;
        burst("t4n", 2'b01, b, 6'd3);
        nack_all = 1'b0;
        chk("t4n_nexec", ex_addr_q.size() - ex0, RETRY_MAX + 1);
        for (int i = 0; i < RETRY_MAX + 1; i++) chk_exec("t4n", i, b, 1'b1);
        chk("t4n_nrd", rd_q.size() - rd0, 0);
        chk("t4n_err", err, 1'b1);
        chk("t4n_err_code", err_code, 2'b01);

        // address wrap at the top of the 16-bit space
        wbuf[0] = 8'($urandom); wbuf[1] = 8'($urandom);
        burst("t5w", 2'b00, 16'hFFFF, 6'd2);
        burst("t5r", 2'b01, 16'hFFFF, 6'd2);
        chk_exec("t5_0", 0, 16'hFFFF, 1'b1);
        chk_exec("t5_1", 1, 16'h0000, 1'b1);
        chk("t5_rd0", rd_q[rd0], wbuf[0]);
        chk("t5_rd1", rd_q[rd0 + 1], wbuf[1]);
        chk("t5_err", err, 1'b0);

        // bad requests: zero length and illegal mode
        burst("t5z", 2'b00, 16'h1234, 6'd0);
        chk("t5z_latency", cycles, 1);
        chk("t5z_nexec", ex_addr_q.size() - ex0, 0);
        chk("t5z_err", err, 1'b1);
        chk("t5z_err_code", err_code, 2'b11);
        burst("t5m", 2'b11, 16'h1234, 6'd2);
        chk("t5m_nexec", ex_addr_q.size() - ex0, 0);
        chk("t5m_err_code", err_code, 2'b11);
        burst("t5c", 2'b01, 16'hFFFF, 6'd1);
        chk("t5c_err_cleared", err, 1'b0);
        chk("t5c_err_code", err_code, 2'b00);

        // reset during the write delay of byte 1 of a 3-byte write
        b = 16'($urandom);
        for (int i = 0; i < 64; i++) wbuf[i] = 8'($urandom);
        launch(2'b00, b, 6'd3);
        cycles = 0;
        while (!(ex_addr_q.size() == ex0 + 2 && i2c_done) && cycles < 5000) begin
            @(negedge dri_clk);
            cycles++;
        end
        chk("t6_reached_byte1", cycles < 5000, 1'b1);
        repeat (5) @(negedge dri_clk);
        chk("t6_busy_before", busy, 1'b1);
        chk("t6_idx_before", byte_idx, 6'd1);
        sys_rst_n = 1'b0;
        dn0 = done_cnt;
        #1;
        chk_quiet_outputs("t6_rst");
        repeat (3) @(negedge dri_clk);
        sys_rst_n = 1'b1;
        @(negedge dri_clk);
        chk("t6_no_done", done_cnt - dn0, 0);
        chk("t6_nexec_abort", ex_addr_q.size() - ex0, 2);
        b = 16'($urandom);
        burst("t6n", 2'b00, b, 6'd1);
        chk("t6n_nexec", ex_addr_q.size() - ex0, 1);
        chk_exec("t6n", 0, b, 1'b0);
        chk("t6n_data", ex_dat_q[ex0], wbuf[0]);
        chk("t6n_err", err, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
